sipo_y: RTL and testbench
=========================

Name: sipo_y

Overview:
Serial-in, parallel-out collector for the PE array's y (complex, real/imag packed) results. Accepts one 2*DATA_WIDTH word per valid cycle into a PE_NUM-deep shift chain. Presents the full chain as one PE_NUM*2*DATA_WIDTH vector whenever a group of PE_NUM words completes, or on demand via shift_v. Sits between the serial y stream and the array-wide parallel y bus.

Parameters:
DATA_WIDTH, default `DATA_WIDTH (16) from parameters.vh, width of one real or imaginary component; word width is 2*DATA_WIDTH (32).
PE_NUM, default `PE_NUM (8) from parameters.vh, number of words per parallel output (chain depth).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
ce  input  1  clock enable; when low, all state holds
shift_v  input  1  emit request: present current chain contents on p_out
s_in_v  input  1  s_in is valid this cycle; load it
s_in  input  2*DATA_WIDTH  serial input word
p_out_v  output  1  p_out valid, one cycle per emission
p_out  output  PE_NUM*2*DATA_WIDTH  parallel output; slice k = bits [k*2*DATA_WIDTH +: 2*DATA_WIDTH] = chain entry sr[k]

Behaviour:
- Reset: rst sampled high at a rising edge clears sr[0..PE_NUM-1], cnt, p_out and p_out_v to 0. rst has priority over ce and all other inputs, including mid-group.
- ce low, rst low: sr, cnt and p_out hold; p_out_v is cleared to 0, so a valid pulse is never stretched.
- Load (ce and s_in_v): sr[0] <= s_in; sr[k] <= sr[k-1] for k = 1..PE_NUM-1. The oldest word moves toward the top slice.
- cnt (width clog2(PE_NUM)) counts loads in the current group and wraps from PE_NUM-1 to 0.
- Group complete: a load with cnt == PE_NUM-1 gives p_out <= post-load chain and p_out_v <= 1 at the same edge. Registered, 1-cycle latency: valid in the cycle after the completing word is sampled.
- Emit (ce and shift_v, s_in_v low): p_out <= current chain; p_out_v <= 1; cnt <= 0; chain unchanged. Holding shift_v gives one emission per cycle with identical p_out.
- Simultaneous s_in_v and shift_v: the load executes; p_out <= post-load chain; p_out_v <= 1; cnt <= 0.
- Otherwise: p_out_v <= 0 and p_out holds its last value.
- No back-pressure; the consumer must take p_out in the p_out_v cycle.

Decomposition:
- `DATA_WIDTH and `PE_NUM come from the shared parameters.vh include (package); no new typedefs.
- Single flat module with a generate loop over the chain; no sub-module needed.

Test Plan:
- Reset: hold rst for 5 cycles with s_in_v=1 -> p_out=0, p_out_v=0 throughout; the first group after release starts at cnt=0.
- Group load: ce=1, load 0,1,...,7 on consecutive cycles -> exactly one p_out_v pulse, in the cycle after word 7 is sampled, with slice0=7, slice1=6, ..., slice7=0.
- Continuous stream: load 0..32 (33 words) back-to-back -> 4 pulses spaced 8 cycles apart with groups {0..7}, {8..15}, {16..23}, {24..31}; then cnt=1 with sr[0]=32.
- Flush: after the stream above, shift_v=1 for 16 cycles -> p_out_v=1 for 16 cycles, each with slice0=32, slice1=31, ..., slice7=25; p_out_v=0 after shift_v drops; cnt=0.
- ce gating: ce=0 for 3 cycles mid-group with s_in_v=1 -> no chain change, no pulse; the group completes 8 enabled loads later.
- Simultaneous: with cnt=3, assert s_in_v (s_in=0xA5A5A5A5) and shift_v together -> p_out_v=1; slice0=0xA5A5A5A5; the next group needs 8 further loads.

Source files
------------

// File: rtl/sipo_y_pkg.sv
// Shared sizing for the y-result serial-to-parallel collector.
// Defaults describe a complex word made of two DATA_WIDTH components.
package sipo_y_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_PE_NUM     = 8;

    // Width of a group counter able to hold 0..pe_num-1; never narrower than one bit.
    function automatic int cnt_width(input int pe_num);
        return (pe_num > 1) ? $clog2(pe_num) : 1;
    endfunction

endpackage

// File: rtl/sipo_y.sv
// Serial-in, parallel-out collector: shifts complex y words into a PE_NUM-deep chain
// and publishes the whole chain on group completion or on an explicit emit request.
module sipo_y
    import sipo_y_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PE_NUM     = DEF_PE_NUM
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic                           shift_v,
    input  logic                           s_in_v,
    input  logic [2*DATA_WIDTH-1:0]        s_in,
    output logic                           p_out_v,
    output logic [PE_NUM*2*DATA_WIDTH-1:0] p_out
);

    localparam int WORD_W = 2 * DATA_WIDTH;
    localparam int CNT_W  = cnt_width(PE_NUM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PE_NUM - 1);

    logic [WORD_W-1:0]        sr_q [PE_NUM];
    logic [WORD_W-1:0]        sr_d [PE_NUM];
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [PE_NUM*WORD_W-1:0] p_out_q, p_out_d;
    logic                     p_out_v_q, p_out_v_d;
    logic [PE_NUM*WORD_W-1:0] post_chain;

    logic load;
    logic group_done;
    logic emit;

    assign load       = ce && s_in_v;
    assign group_done = load && (cnt_q == CNT_LAST);
    assign emit       = (ce && shift_v) || group_done;

    // sr_d is the post-load chain, which equals the current chain when nothing loads,
    // so one packed view serves both group completion and explicit emits.
    genvar gi;
    generate
        for (gi = 0; gi < PE_NUM; gi++) begin : g_chain
            if (gi == 0) begin : g_head
                assign sr_d[gi] = load ? s_in : sr_q[gi];
            end else begin : g_body
                assign sr_d[gi] = load ? sr_q[gi-1] : sr_q[gi];
            end
            assign post_chain[gi*WORD_W +: WORD_W] = sr_d[gi];
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (ce) begin
            if (shift_v) begin
                cnt_d = '0;
            end else if (s_in_v) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        p_out_d   = p_out_q;
        p_out_v_d = 1'b0;
        if (emit) begin
            p_out_d   = post_chain;
            p_out_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PE_NUM; i++) begin
                sr_q[i] <= '0;
            end
            cnt_q     <= '0;
            p_out_q   <= '0;
            p_out_v_q <= 1'b0;
        end else begin
            for (int i = 0; i < PE_NUM; i++) begin
                sr_q[i] <= sr_d[i];
            end
            cnt_q     <= cnt_d;
            p_out_q   <= p_out_d;
            p_out_v_q <= p_out_v_d;
        end
    end

    assign p_out   = p_out_q;
    assign p_out_v = p_out_v_q;

endmodule

// File: tb/tb_sipo_y.sv
// Randomised and directed stimulus for sipo_y, checked by a queue scoreboard fed
// from a word-history model and drained by an independent monitor.
module tb_sipo_y;
    import sipo_y_pkg::*;

    localparam int DW  = DEF_DATA_WIDTH;
    localparam int PN  = DEF_PE_NUM;
    localparam int WW  = 2 * DW;
    localparam int PW  = PN * WW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          shift_v = 1'b0;
    logic          s_in_v = 1'b0;
    logic [WW-1:0] s_in = '0;
    logic          p_out_v;
    logic [PW-1:0] p_out;

    sipo_y #(.DATA_WIDTH(DW), .PE_NUM(PN)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .shift_v (shift_v),
        .s_in_v  (s_in_v),
        .s_in    (s_in),
        .p_out_v (p_out_v),
        .p_out   (p_out)
    );

    always #5 clk = ~clk;

    // Reference model: recent word history (newest at back) and loads-in-group count.
    logic [WW-1:0] hist[$];
    int            grp_loads;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] last_p;
    int            total = 0;
    int            bad = 0;
    bit            mon_en = 0;
    int            pulses = 0;

    function automatic logic [PW-1:0] chain_view();
        logic [PW-1:0] v;
        v = '0;
        for (int k = 0; k < PN; k++) begin
            int idx;
            idx = hist.size() - 1 - k;
            if (idx >= 0) v[k*WW +: WW] = hist[idx];
        end
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic c, input logic sv,
                              input logic lv, input logic [WW-1:0] w);
        if (r) begin
            hist.delete();
            grp_loads = 0;
            last_p = '0;
        end else if (c) begin
            bit fire;
            fire = sv;
            if (lv) begin
                hist.push_back(w);
                if (hist.size() > PN) void'(hist.pop_front());
                grp_loads++;
                if (grp_loads == PN) fire = 1;
            end
            if (fire) begin
                exp_q.push_back(chain_view());
                grp_loads = 0;
            end
        end
    endtask

    task automatic step(input logic r, input logic c, input logic sv,
                        input logic lv, input logic [WW-1:0] w);
        rst = r; ce = c; shift_v = sv; s_in_v = lv; s_in = w;
        @(posedge clk);
        model_edge(r, c, sv, lv, w);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_v;
            exp_v = (exp_q.size() > 0);
            total++;
            if (p_out_v !== exp_v) begin
                bad++;
                $display("FAIL valid t=%0t got=%0b want=%0b", $time, p_out_v, exp_v);
            end
            if (exp_v) begin
                last_p = exp_q.pop_front();
                pulses++;
            end
            total++;
            if (p_out !== last_p) begin
                bad++;
                $display("FAIL p_out t=%0t got=%h want=%h", $time, p_out, last_p);
            end
            if (p_out_v === 1'b1)
                $display("emit t=%0t p_out=%h", $time, p_out);
        end
    end

    initial begin
        int p0;
        hist.delete();
        grp_loads = 0;
        last_p = '0;

        // Reset held with traffic present: outputs must stay zero.
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 1, WW'($urandom));
            mon_en = 1;
        end

        // One group of 0..7: single pulse, slice0 = 7.
        p0 = pulses;
        for (int i = 0; i < PN; i++) step(0, 1, 0, 1, WW'(i));
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        total++;
        if (pulses - p0 != 1) begin
            bad++;
            $display("FAIL group_pulses got=%0d want=1", pulses - p0);
        end

        // 33-word stream then a 16-cycle flush.
        p0 = pulses;
        for (int i = 0; i <= 32; i++) step(0, 1, 0, 1, WW'(i));
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, '0);
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        total++;
        if (pulses - p0 != 20) begin
            bad++;
            $display("FAIL stream_flush_pulses got=%0d want=20", pulses - p0);
        end

        // ce gating mid-group.
        p0 = pulses;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, WW'(32'h100 + i));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, WW'(32'hDEAD0000 + i));
        for (int i = 3; i < PN; i++) step(0, 1, 0, 1, WW'(32'h100 + i));
        step(0, 1, 0, 0, '0);
        total++;
        if (pulses - p0 != 1) begin
            bad++;
            $display("FAIL ce_gate_pulses got=%0d want=1", pulses - p0);
        end

        // Simultaneous load+emit at cnt=3, then a fresh group of 8.
        p0 = pulses;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, WW'(32'h200 + i));
        step(0, 1, 1, 1, WW'(32'hA5A5A5A5));
        for (int i = 0; i < PN - 1; i++) step(0, 1, 0, 1, WW'(32'h300 + i));
        step(0, 1, 0, 0, '0);
        total++;
        if (pulses - p0 != 1) begin
            bad++;
            $display("FAIL simul_early_pulses got=%0d want=1", pulses - p0);
        end
        step(0, 1, 0, 1, WW'(32'h3FF));
        step(0, 1, 0, 0, '0);
        total++;
        if (pulses - p0 != 2) begin
            bad++;
            $display("FAIL simul_regroup_pulses got=%0d want=2", pulses - p0);
        end

        // Random traffic, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6),
                 WW'($urandom));
        end
        step(0, 1, 0, 0, '0);
        step(0, 1, 0, 0, '0);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
